// File: rtl/lsq_pkg.sv
// Shared definitions for the least-squares regression datapath:
// sequencer state encoding and default job/sample dimensions.
package lsq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_INV   = 3'd4,
    S_DONE  = 3'd5
  } lsq_state_e;

  localparam int LSQ_N_SAMPLES = 1024;
  localparam int LSQ_X_W       = 12;
  localparam int LSQ_Y_W       = 16;

endpackage

// File: rtl/lsq_seq_ctrl_if.sv
// Sample stream and accumulator bus between the sequencer and its
// neighbours. The producer/accumulator side is master, the sequencer slave.
interface lsq_seq_ctrl_if #(
  parameter int X_W = 12,
  parameter int Y_W = 16
);
  logic           s_valid;
  logic           s_ready;
  logic [X_W-1:0] s_x;
  logic [Y_W-1:0] s_y;
  logic           acc_clr;
  logic           acc_en;
  logic [X_W-1:0] acc_x;
  logic [Y_W-1:0] acc_y;

  modport master (
    output s_valid, s_x, s_y,
    input  s_ready, acc_clr, acc_en, acc_x, acc_y
  );

  modport slave (
    input  s_valid, s_x, s_y,
    output s_ready, acc_clr, acc_en, acc_x, acc_y
  );
endinterface

// File: rtl/lsq_seq_ctrl.sv
// Least-squares regression sequencer: clears the accumulators, streams
// N_SAMPLES (x, y) pairs through one register stage into them, then runs
// the 3x3 inverter and pulses done. abort returns to IDLE from any state.
module lsq_seq_ctrl
  import lsq_pkg::*;
#(
  parameter int N_SAMPLES = LSQ_N_SAMPLES,
  parameter int CNT_W     = 11,
  parameter int X_W       = LSQ_X_W,
  parameter int Y_W       = LSQ_Y_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_req,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             inv_start,
  input  logic             inv_done,
  output logic [CNT_W-1:0] sample_cnt,
  lsq_seq_ctrl_if.slave    sif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  lsq_state_e       state_q, state_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic             acc_en_q, acc_en_d;
  logic [X_W-1:0]   acc_x_q, acc_x_d;
  logic [Y_W-1:0]   acc_y_q, acc_y_d;
  logic             hs;

  // State, counter and sample register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= '0;
      acc_en_q     <= 1'b0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      acc_en_q     <= acc_en_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
    end
  end

  // Next-state logic; abort overrides everything except in IDLE, and the
  // sample registers hold across an abort.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    acc_en_d     = 1'b0;
    acc_x_d      = acc_x_q;
    acc_y_d      = acc_y_q;
    hs           = sif.s_valid && (state_q == S_ACCUM);

    case (state_q)
      S_IDLE:  if (job_req) state_d = S_CLEAR;
      S_CLEAR: begin
        sample_cnt_d = '0;
        state_d      = S_ACCUM;
      end
      S_ACCUM: begin
        if (hs) begin
          acc_x_d      = sif.s_x;
          acc_y_d      = sif.s_y;
          acc_en_d     = 1'b1;
          sample_cnt_d = sample_cnt_q + 1'b1;
          if (sample_cnt_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_INV;
      S_INV:   if (inv_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      sample_cnt_d = '0;
      acc_en_d     = 1'b0;
      acc_x_d      = acc_x_q;
      acc_y_d      = acc_y_q;
    end
  end

  // Control outputs decoded from state only (s_ready never sees s_valid).
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    inv_start   = (state_q == S_INV);
    sif.s_ready = (state_q == S_ACCUM);
    sif.acc_clr = (state_q == S_CLEAR);
    sif.acc_en  = acc_en_q;
    sif.acc_x   = acc_x_q;
    sif.acc_y   = acc_y_q;
    sample_cnt  = sample_cnt_q;
  end

endmodule

// File: tb/tb_lsq_seq_ctrl.sv
// Directed bench for lsq_seq_ctrl: DUT A with N_SAMPLES=4, DUT B with
// N_SAMPLES=1, shared clock and reset.
module tb_lsq_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  lsq_seq_ctrl_if #(.X_W(12), .Y_W(16)) ifa ();
  lsq_seq_ctrl_if #(.X_W(12), .Y_W(16)) ifb ();

  logic       a_job_req, a_abort, a_inv_done, a_busy, a_done, a_inv_start;
  logic [2:0] a_cnt;
  logic       b_job_req, b_abort, b_inv_done, b_busy, b_done, b_inv_start;
  logic [1:0] b_cnt;

  lsq_seq_ctrl #(.N_SAMPLES(4), .CNT_W(3), .X_W(12), .Y_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .job_req(a_job_req), .abort(a_abort),
    .busy(a_busy), .done(a_done), .inv_start(a_inv_start),
    .inv_done(a_inv_done), .sample_cnt(a_cnt), .sif(ifa.slave)
  );

  lsq_seq_ctrl #(.N_SAMPLES(1), .CNT_W(2), .X_W(12), .Y_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .job_req(b_job_req), .abort(b_abort),
    .busy(b_busy), .done(b_done), .inv_start(b_inv_start),
    .inv_done(b_inv_done), .sample_cnt(b_cnt), .sif(ifb.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pulses;

  initial begin
    a_job_req = 0; a_abort = 0; a_inv_done = 0;
    b_job_req = 0; b_abort = 0; b_inv_done = 0;
    ifa.s_valid = 0; ifa.s_x = '0; ifa.s_y = '0;
    ifb.s_valid = 0; ifb.s_x = '0; ifb.s_y = '0;

    // Reset state
    #12;
    check("rst_busy", a_busy, 0);
    check("rst_ready", ifa.s_ready, 0);
    check("rst_clr", ifa.acc_clr, 0);
    check("rst_en", ifa.acc_en, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_inv", a_inv_start, 0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // Job 1: continuous stream x=1..4, y=10..40
    a_job_req = 1; ifa.s_valid = 1; ifa.s_x = 12'd1; ifa.s_y = 16'd10;
    tick();
    a_job_req = 0;
    check("j1_clr", ifa.acc_clr, 1);
    check("j1_busy", a_busy, 1);
    check("j1_clr_ready", ifa.s_ready, 0);
    tick();
    check("j1_clr_once", ifa.acc_clr, 0);
    check("j1_ready", ifa.s_ready, 1);
    check("j1_en0", ifa.acc_en, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("j1_en", ifa.acc_en, 1);
      check("j1_x", ifa.acc_x, i);
      check("j1_y", ifa.acc_y, 10 * i);
      check("j1_cnt", a_cnt, i);
      ifa.s_x = 12'(i + 1); ifa.s_y = 16'(10 * (i + 1));
    end
    check("j1_drain_ready", ifa.s_ready, 0);
    check("j1_drain_inv", a_inv_start, 0);
    ifa.s_valid = 0;
    tick();
    check("j1_inv_start", a_inv_start, 1);
    check("j1_inv_en", ifa.acc_en, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("j1_inv_hold", a_inv_start, 1);
      check("j1_no_done", a_done, 0);
    end
    a_inv_done = 1;
    tick();
    a_inv_done = 0;
    check("j1_done", a_done, 1);
    check("j1_done_inv", a_inv_start, 0);
    tick();
    check("j1_done_once", a_done, 0);
    check("j1_idle_busy", a_busy, 0);
    check("j1_cnt_hold", a_cnt, 4);

    // Job 2: s_valid toggling
    a_job_req = 1;
    tick();
    a_job_req = 0;
    check("j2_clr", ifa.acc_clr, 1);
    tick();
    check("j2_cnt0", a_cnt, 0);
    pulses = 0;
    for (int c = 0; c < 7; c++) begin
      ifa.s_valid = (c % 2 == 0);
      ifa.s_x = 12'(c + 1); ifa.s_y = 16'(c + 100);
      tick();
      check("j2_en", ifa.acc_en, (c % 2 == 0));
      check("j2_cnt", a_cnt, c / 2 + 1);
      if (ifa.acc_en) pulses++;
    end
    check("j2_drain_ready", ifa.s_ready, 0);
    ifa.s_valid = 1; ifa.s_x = 12'd99;
    tick();
    check("j2_fifth_en", ifa.acc_en, 0);
    check("j2_fifth_cnt", a_cnt, 4);
    check("j2_inv", a_inv_start, 1);
    check("j2_inv_ready", ifa.s_ready, 0);
    check("j2_pulses", pulses, 4);
    check("j2_last_x", ifa.acc_x, 7);
    ifa.s_valid = 0;
    a_inv_done = 1;
    tick();
    a_inv_done = 0;
    check("j2_done", a_done, 1);
    tick();

    // Job 3: abort during ACCUM at sample_cnt=2
    a_job_req = 1;
    tick();
    a_job_req = 0;
    ifa.s_valid = 1;
    tick();
    for (int i = 1; i <= 2; i++) begin
      ifa.s_x = 12'(i); ifa.s_y = 16'(i);
      tick();
    end
    check("j3_cnt2", a_cnt, 2);
    a_abort = 1; ifa.s_x = 12'd3; ifa.s_y = 16'd3;
    tick();
    a_abort = 0; ifa.s_valid = 0;
    check("j3_busy", a_busy, 0);
    check("j3_ready", ifa.s_ready, 0);
    check("j3_en", ifa.acc_en, 0);
    check("j3_cnt", a_cnt, 0);
    check("j3_x_hold", ifa.acc_x, 2);
    check("j3_done", a_done, 0);
    check("j3_inv", a_inv_start, 0);
    a_job_req = 1;
    tick();
    a_job_req = 0;
    check("j3_restart_clr", ifa.acc_clr, 1);
    check("j3_restart_cnt", a_cnt, 0);

    // Job 4: job_req in ACCUM ignored, abort together with inv_done
    ifa.s_valid = 1;
    tick();
    a_job_req = 1;
    tick();
    a_job_req = 0;
    check("j4_cnt1", a_cnt, 1);
    check("j4_no_clr", ifa.acc_clr, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("j4_no_clr_loop", ifa.acc_clr, 0);
    end
    ifa.s_valid = 0;
    check("j4_cnt4", a_cnt, 4);
    tick();
    check("j4_inv", a_inv_start, 1);
    a_abort = 1; a_inv_done = 1;
    tick();
    a_abort = 0; a_inv_done = 0;
    check("j4_abort_done", a_done, 0);
    check("j4_abort_busy", a_busy, 0);
    check("j4_abort_inv", a_inv_start, 0);
    tick();
    check("j4_still_no_done", a_done, 0);

    // Job 5: asynchronous reset mid-INV
    a_job_req = 1;
    tick();
    a_job_req = 0; ifa.s_valid = 1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    ifa.s_valid = 0;
    tick();
    check("j5_inv", a_inv_start, 1);
    #2;
    rst_n = 0;
    #1;
    check("j5_rst_inv", a_inv_start, 0);
    check("j5_rst_busy", a_busy, 0);
    check("j5_rst_cnt", a_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    a_inv_done = 1;
    tick();
    check("j5_no_done", a_done, 0);
    check("j5_idle", a_busy, 0);
    a_inv_done = 0;

    // DUT B: N_SAMPLES=1, extreme sample values
    b_job_req = 1;
    tick();
    b_job_req = 0;
    check("b_clr", ifb.acc_clr, 1);
    ifb.s_valid = 1; ifb.s_x = 12'hFFF; ifb.s_y = 16'hFFFF;
    tick();
    check("b_ready", ifb.s_ready, 1);
    tick();
    ifb.s_valid = 0;
    check("b_en", ifb.acc_en, 1);
    check("b_x", ifb.acc_x, 12'hFFF);
    check("b_y", ifb.acc_y, 16'hFFFF);
    check("b_cnt", b_cnt, 1);
    check("b_drain_ready", ifb.s_ready, 0);
    tick();
    check("b_en_off", ifb.acc_en, 0);
    check("b_inv", b_inv_start, 1);
    check("b_cnt_hold", b_cnt, 1);
    b_inv_done = 1;
    tick();
    b_inv_done = 0;
    check("b_done", b_done, 1);
    tick();
    check("b_idle", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
